// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: opcodes, functs, ALU selects,
// datapath mux selects, state encoding and the control-word payload.
package mc_pkg;

    localparam int unsigned ST_W   = 4;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned ALU_W  = 3;
    localparam int unsigned AOP_W  = 2;
    localparam int unsigned SEL_W  = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    localparam logic [AOP_W-1:0] AOP_ADD   = 2'b00;
    localparam logic [AOP_W-1:0] AOP_SUB   = 2'b01;
    localparam logic [AOP_W-1:0] AOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_REG    = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    // Encoding 13 is reserved for the optional bne state even when it is compiled out.
    typedef enum logic [ST_W-1:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEMADR    = 4'd3,
        S_MEMRD     = 4'd4,
        S_MEMWB     = 4'd5,
        S_MEMWR     = 4'd6,
        S_EXEC      = 4'd7,
        S_ALUWB     = 4'd8,
        S_BRANCH    = 4'd9,
        S_ADDIEX    = 4'd10,
        S_ADDIWB    = 4'd11,
        S_JUMP      = 4'd12,
        S_BRANCH_NE = 4'd13
    } state_e;

    typedef struct packed {
        logic             alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] pc_src;
        logic             ir_wr;
        logic             iord;
        logic             mem_wr;
        logic             reg_wr;
        logic             reg_dst;
        logic             mem_to_reg;
        logic             illegal;
    } ctrl_t;

    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_ctrl_alu_decoder.sv
// ALU operation decoder: fixed ADD/SUB, or R-type selection by funct.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [AOP_W-1:0] alu_op_i,
    input  logic [OP_W-1:0]  funct_i,
    output logic [ALU_W-1:0] alu_ctrl_o,
    output logic             illegal_funct_o
);

    always_comb begin
        alu_ctrl_o      = ALU_ADD;
        illegal_funct_o = 1'b0;
        case (alu_op_i)
            AOP_ADD: alu_ctrl_o = ALU_ADD;
            AOP_SUB: alu_ctrl_o = ALU_SUB;
            AOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alu_ctrl_o = ALU_ADD;
                    FN_SUB:  alu_ctrl_o = ALU_SUB;
                    FN_AND:  alu_ctrl_o = ALU_AND;
                    FN_OR:   alu_ctrl_o = ALU_OR;
                    FN_SLT:  alu_ctrl_o = ALU_SLT;
                    default: illegal_funct_o = 1'b1;
                endcase
            end
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle controller FSM driving the shared-ALU datapath.
// Define MC_CTRL_BNE_EN to add bne support; otherwise bne decodes as illegal.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned STATE_W = ST_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    opcode,
    input  logic [OP_W-1:0]    funct,
    input  logic               zero,
    output logic [ALU_W-1:0]   alu_ctrl,
    output logic               alu_src_a,
    output logic [SEL_W-1:0]   alu_src_b,
    output logic [SEL_W-1:0]   pc_src,
    output logic               pc_en,
    output logic               ir_wr,
    output logic               iord,
    output logic               mem_wr,
    output logic               reg_wr,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    state_e           state_q, state_d;
    ctrl_t            ctrl;
    logic             alu_use;
    logic [AOP_W-1:0] alu_op;
    logic             pc_write;
    logic             branch;
    logic             branch_ne;
    logic [ALU_W-1:0] dec_ctrl;
    logic             illegal_funct;

    alu_decoder u_alu_decoder (
        .alu_op_i        (alu_op),
        .funct_i         (funct),
        .alu_ctrl_o      (dec_ctrl),
        .illegal_funct_o (illegal_funct)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RESET;
        else        state_q <= state_d;
    end

    // Next state and Moore control word; everything not set in a state stays 0.
    always_comb begin
        state_d   = S_FETCH;
        ctrl      = '0;
        alu_use   = 1'b0;
        alu_op    = AOP_ADD;
        pc_write  = 1'b0;
        branch    = 1'b0;
        branch_ne = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                alu_use        = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_wr     = 1'b1;
                pc_write       = 1'b1;
                state_d        = S_DECODE;
            end
            S_DECODE: begin
                alu_use        = 1'b1;
                ctrl.alu_src_b = SRCB_IMM_SH;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       state_d = S_BRANCH_NE;
`endif
                    default: begin
                        ctrl.illegal = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_use        = 1'b1;
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_d        = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctrl.iord = 1'b1;
                state_d   = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.reg_wr     = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord   = 1'b1;
                ctrl.mem_wr = 1'b1;
            end
            S_EXEC: begin
                alu_use        = 1'b1;
                alu_op         = AOP_FUNCT;
                ctrl.alu_src_a = 1'b1;
                ctrl.illegal   = illegal_funct;
                state_d        = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_wr  = 1'b1;
                ctrl.reg_dst = 1'b1;
            end
            S_BRANCH: begin
                alu_use        = 1'b1;
                alu_op         = AOP_SUB;
                ctrl.alu_src_a = 1'b1;
                ctrl.pc_src    = PCSRC_ALUOUT;
                branch         = 1'b1;
            end
`ifdef MC_CTRL_BNE_EN
            S_BRANCH_NE: begin
                alu_use        = 1'b1;
                alu_op         = AOP_SUB;
                ctrl.alu_src_a = 1'b1;
                ctrl.pc_src    = PCSRC_ALUOUT;
                branch_ne      = 1'b1;
            end
`endif
            S_ADDIEX: begin
                alu_use        = 1'b1;
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_d        = S_ADDIWB;
            end
            S_ADDIWB: ctrl.reg_wr = 1'b1;
            S_JUMP: begin
                ctrl.pc_src = PCSRC_JUMP;
                pc_write    = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        if (state_q == S_MEMADR && !is_mem_op(opcode)) state_d = S_FETCH;
    end

    // Only Mealy path: conditional PC update from the ALU zero flag.
    assign pc_en      = pc_write | (branch & zero) | (branch_ne & ~zero);
    assign alu_ctrl   = alu_use ? dec_ctrl : '0;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign pc_src     = ctrl.pc_src;
    assign ir_wr      = ctrl.ir_wr;
    assign iord       = ctrl.iord;
    assign mem_wr     = ctrl.mem_wr;
    assign reg_wr     = ctrl.reg_wr;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign illegal    = ctrl.illegal;
    assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: stimulus pushes per-cycle expected control words,
// a monitor pops and compares them against the DUT outputs.
module tb_mc_ctrl;

    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] RT  = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101;
    localparam logic [5:0] ADI = 6'b001000;
    localparam logic [5:0] JMP = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] alu_ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       ir_wr;
    logic       iord;
    logic       mem_wr;
    logic       reg_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic [3:0] state;

    mc_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .alu_ctrl   (alu_ctrl),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .pc_en      (pc_en),
        .ir_wr      (ir_wr),
        .iord       (iord),
        .mem_wr     (mem_wr),
        .reg_wr     (reg_wr),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fl = {pc_en, ir_wr, iord, mem_wr, reg_wr, reg_dst, mem_to_reg, illegal}
    typedef struct packed {
        logic [3:0] st;
        logic [2:0] alu;
        logic       sa;
        logic [1:0] sb;
        logic [1:0] ps;
        logic [7:0] fl;
    } vec_t;

    vec_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    event  kick;

    function automatic vec_t dut_vec();
        vec_t v;
        v.st  = state;
        v.alu = alu_ctrl;
        v.sa  = alu_src_a;
        v.sb  = alu_src_b;
        v.ps  = pc_src;
        v.fl  = {pc_en, ir_wr, iord, mem_wr, reg_wr, reg_dst, mem_to_reg, illegal};
        return v;
    endfunction

    initial begin : monitor
        vec_t  e;
        vec_t  g;
        string n;
        forever begin
            @(negedge clk or kick);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                g = dut_vec();
                n_cmp++;
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL %s: got st=%0d alu=%b sa=%b sb=%b ps=%b fl=%b, want st=%0d alu=%b sa=%b sb=%b ps=%b fl=%b",
                             n, g.st, g.alu, g.sa, g.sb, g.ps, g.fl, e.st, e.alu, e.sa, e.sb, e.ps, e.fl);
                end
            end
        end
    end

    task automatic push(input string nm, input logic [3:0] st, input logic [2:0] alu, input logic sa,
                        input logic [1:0] sb, input logic [1:0] ps, input logic [7:0] fl);
        vec_t v;
        v = {st, alu, sa, sb, ps, fl};
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    task automatic step(input string nm, input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input logic [3:0] st, input logic [2:0] alu, input logic sa,
                        input logic [1:0] sb, input logic [1:0] ps, input logic [7:0] fl);
        opcode = op;
        funct  = fn;
        zero   = z;
        push(nm, st, alu, sa, sb, ps, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string nm, input logic [5:0] op, input logic [5:0] fn, input logic z);
        step({nm, ".fetch"}, op, fn, z, 4'd1, 3'b010, 1'b0, 2'b01, 2'b00, 8'b1100_0000);
    endtask

    task automatic decode(input string nm, input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input logic ill);
        step({nm, ".decode"}, op, fn, z, 4'd2, 3'b010, 1'b0, 2'b11, 2'b00, {7'b0, ill});
    endtask

    task automatic rtype(input string nm, input logic [5:0] fn, input logic [2:0] alu, input logic ill);
        fetch(nm, RT, fn, 1'b0);
        decode(nm, RT, fn, 1'b0, 1'b0);
        step({nm, ".exec"}, RT, fn, 1'b0, 4'd7, alu, 1'b1, 2'b00, 2'b00, {7'b0, ill});
        step({nm, ".aluwb"}, RT, fn, 1'b0, 4'd8, 3'b000, 1'b0, 2'b00, 2'b00, 8'b0000_1100);
    endtask

    initial begin : stim
        rst_n  = 1'b0;
        opcode = '0;
        funct  = '0;
        zero   = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) step("reset", 6'd0, 6'd0, 1'b0, 4'd0, 3'b000, 1'b0, 2'b00, 2'b00, 8'b0);
        rst_n = 1'b1;
        step("reset_release", 6'd0, 6'd0, 1'b0, 4'd0, 3'b000, 1'b0, 2'b00, 2'b00, 8'b0);

        fetch("lw", LW, 6'd0, 1'b0);
        decode("lw", LW, 6'd0, 1'b0, 1'b0);
        step("lw.memadr", LW, 6'd0, 1'b0, 4'd3, 3'b010, 1'b1, 2'b10, 2'b00, 8'b0);
        step("lw.memrd",  LW, 6'd0, 1'b0, 4'd4, 3'b000, 1'b0, 2'b00, 2'b00, 8'b0010_0000);
        step("lw.memwb",  LW, 6'd0, 1'b0, 4'd5, 3'b000, 1'b0, 2'b00, 2'b00, 8'b0000_1010);

        rtype("sub", 6'b100010, 3'b110, 1'b0);
        rtype("slt", 6'b101010, 3'b111, 1'b0);
        rtype("and", 6'b100100, 3'b000, 1'b0);
        rtype("badfn", 6'b111111, 3'b010, 1'b1);

        fetch("beq1", BEQ, 6'd0, 1'b1);
        decode("beq1", BEQ, 6'd0, 1'b1, 1'b0);
        step("beq1.branch", BEQ, 6'd0, 1'b1, 4'd9, 3'b110, 1'b1, 2'b00, 2'b01, 8'b1000_0000);
        fetch("beq0", BEQ, 6'd0, 1'b0);
        decode("beq0", BEQ, 6'd0, 1'b0, 1'b0);
        step("beq0.branch", BEQ, 6'd0, 1'b0, 4'd9, 3'b110, 1'b1, 2'b00, 2'b01, 8'b0000_0000);

        fetch("addi", ADI, 6'd0, 1'b0);
        decode("addi", ADI, 6'd0, 1'b0, 1'b0);
        step("addi.ex", ADI, 6'd0, 1'b0, 4'd10, 3'b010, 1'b1, 2'b10, 2'b00, 8'b0);
        step("addi.wb", ADI, 6'd0, 1'b0, 4'd11, 3'b000, 1'b0, 2'b00, 2'b00, 8'b0000_1000);

        fetch("j", JMP, 6'd0, 1'b0);
        decode("j", JMP, 6'd0, 1'b0, 1'b0);
        step("j.jump", JMP, 6'd0, 1'b0, 4'd12, 3'b000, 1'b0, 2'b00, 2'b10, 8'b1000_0000);

        fetch("illegal", BAD, 6'd0, 1'b0);
        decode("illegal", BAD, 6'd0, 1'b0, 1'b1);

`ifdef MC_CTRL_BNE_EN
        fetch("bne0", BNE, 6'd0, 1'b0);
        decode("bne0", BNE, 6'd0, 1'b0, 1'b0);
        step("bne0.branch", BNE, 6'd0, 1'b0, 4'd13, 3'b110, 1'b1, 2'b00, 2'b01, 8'b1000_0000);
        fetch("bne1", BNE, 6'd0, 1'b1);
        decode("bne1", BNE, 6'd0, 1'b1, 1'b0);
        step("bne1.branch", BNE, 6'd0, 1'b1, 4'd13, 3'b110, 1'b1, 2'b00, 2'b01, 8'b0000_0000);
`else
        fetch("bne", BNE, 6'd0, 1'b0);
        decode("bne", BNE, 6'd0, 1'b0, 1'b1);
`endif

        fetch("sw", SW, 6'd0, 1'b0);
        decode("sw", SW, 6'd0, 1'b0, 1'b0);
        step("sw.memadr", SW, 6'd0, 1'b0, 4'd3, 3'b010, 1'b1, 2'b10, 2'b00, 8'b0);
        step("sw.memwr",  SW, 6'd0, 1'b0, 4'd6, 3'b000, 1'b0, 2'b00, 2'b00, 8'b0011_0000);

        // Second store is cut by an asynchronous reset mid-way through S_MEMWR.
        fetch("swrst", SW, 6'd0, 1'b0);
        decode("swrst", SW, 6'd0, 1'b0, 1'b0);
        step("swrst.memadr", SW, 6'd0, 1'b0, 4'd3, 3'b010, 1'b1, 2'b10, 2'b00, 8'b0);
        push("swrst.memwr", 4'd6, 3'b000, 1'b0, 2'b00, 2'b00, 8'b0011_0000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        push("swrst.async", 4'd0, 3'b000, 1'b0, 2'b00, 2'b00, 8'b0);
        -> kick;
        @(posedge clk);
        #1;
        step("swrst.hold", SW, 6'd0, 1'b0, 4'd0, 3'b000, 1'b0, 2'b00, 2'b00, 8'b0);
        rst_n = 1'b1;
        step("swrst.release", SW, 6'd0, 1'b0, 4'd0, 3'b000, 1'b0, 2'b00, 2'b00, 8'b0);
        fetch("after", RT, 6'b100000, 1'b0);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle controller FSM. It is the driving end of the ALU's `alu_ctrl`/`zero` interface.
- Decodes `opcode`/`funct` from the instruction register and sequences the datapath through fetch, decode, execute, memory and writeback.
- Produces `alu_ctrl` for the 32-bit ALU (010 ADD, 110 SUB, 111 SLT, 000 AND, 001 OR) and consumes the ALU `zero` flag for branches.
- Sits between the instruction register and the shared single-ALU datapath.

Parameters:
- STATE_W, 4, width of `state` register and debug port.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26] from IR
- funct  in  6  instr[5:0] from IR
- zero  in  1  ALU zero flag (result == 0)
- alu_ctrl  out  3  ALU operation select
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- pc_src  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target
- pc_en  out  1  PC write enable
- ir_wr  out  1  IR write enable
- iord  out  1  memory address select, 0 = PC, 1 = ALUOut
- mem_wr  out  1  memory write enable
- reg_wr  out  1  register file write enable
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = memory data
- illegal  out  1  unsupported opcode or funct seen
- state  out  STATE_W  current state, for debug

Behaviour:
- Clock, reset and output style:
  - Single clock, `clk`; asynchronous active-low reset, `rst_n`.
  - Moore outputs decoded from `state`. The only Mealy term is `pc_en = pc_write | (branch & zero)`.
  - Any output not listed for a state is 0.
- Reset:
  - `state` = S_RESET (0); every output is 0.
  - First clock after `rst_n` rises → S_FETCH.
  - Reset mid-instruction abandons the instruction; no write-enable is asserted after `rst_n` falls.
- S_FETCH: `alu_ctrl`=010, `alu_src_b`=01, `ir_wr`=1, `pc_write`=1 → S_DECODE.
- S_DECODE: `alu_ctrl`=010, `alu_src_b`=11 (branch target into ALUOut). Next state by opcode:
  - 100011 lw or 101011 sw → S_MEMADR
  - 000000 R-type → S_EXEC
  - 000100 beq → S_BRANCH
  - 001000 addi → S_ADDIEX
  - 000010 j → S_JUMP
  - any other opcode: `illegal`=1 for this cycle → S_FETCH (acts as a NOP; PC already advanced).
- S_MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_ctrl`=010 → S_MEMRD (lw) or S_MEMWR (sw).
- S_MEMRD: `iord`=1 → S_MEMWB.
- S_MEMWB: `reg_wr`=1, `mem_to_reg`=1 → S_FETCH.
- S_MEMWR: `iord`=1, `mem_wr`=1 → S_FETCH.
- S_EXEC: `alu_src_a`=1, `alu_ctrl` from funct → S_ALUWB.
  - funct 100000 → 010 (ADD), 100010 → 110 (SUB), 100100 → 000 (AND), 100101 → 001 (OR), 101010 → 111 (SLT).
  - Unknown funct → 010 with `illegal`=1.
- S_ALUWB: `reg_wr`=1, `reg_dst`=1 → S_FETCH.
- S_BRANCH: `alu_src_a`=1, `alu_ctrl`=110, `pc_src`=01, `branch`=1 → S_FETCH. `pc_en` follows `zero` in this cycle.
- S_ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_ctrl`=010 → S_ADDIWB.
- S_ADDIWB: `reg_wr`=1 → S_FETCH.
- S_JUMP: `pc_src`=10, `pc_write`=1 → S_FETCH.
- Cycle counts per instruction:

  | Instruction | Cycles |
  |---|---|
  | lw | 5 |
  | sw | 4 |
  | R-type | 4 |
  | addi | 4 |
  | beq | 3 |
  | j | 3 |
  | illegal | 2 |

- Unused `state` encodings → next S_FETCH, all outputs 0.

Optional Feature:
- Macro: MC_CTRL_BNE_EN.
- Defined: opcode 000101 (bne) → S_BRANCH_NE. That state drives the same outputs as S_BRANCH, but `pc_en = ~zero`; 3 cycles.
- Undefined: bne is treated as an illegal opcode (`illegal` pulse, NOP).

Decomposition:
- Package `mc_pkg` holds:
  - opcode constants
  - funct constants
  - `alu_ctrl` encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT)
  - `alu_src_b` and `pc_src` select encodings
  - state encoding localparams
- One combinational sub-module, `alu_decoder` (alu_op[1:0], funct → alu_ctrl, illegal_funct). `mc_ctrl` drives `alu_op`: 00 ADD, 01 SUB, 10 by funct.

Test Plan:
- Reset: hold `rst_n`=0 for 3 cycles → `state`=0 and all enables 0. Release → S_FETCH on the next edge, with `ir_wr`=1, `pc_en`=1, `alu_ctrl`=010.
- lw, opcode 100011 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. `reg_wr`=1 with `mem_to_reg`=1 only in cycle 5; `mem_wr` is never 1.
- R-type SUB then SLT, opcode 000000 with funct 100010, then 101010 → `alu_ctrl`=110 in S_EXEC, then 111 in S_EXEC; `reg_dst`=1 and `reg_wr`=1 in S_ALUWB.
- beq, opcode 000100:
  - with `zero`=1 → `pc_en`=1 and `pc_src`=01 in S_BRANCH;
  - with `zero`=0 → `pc_en`=0;
  - in both cases the next state is FETCH.
- Illegal opcode 111111 → `illegal`=1 for exactly one cycle in S_DECODE, then S_FETCH; `reg_wr`/`mem_wr` stay 0. With MC_CTRL_BNE_EN set, opcode 000101 with `zero`=0 → `pc_en`=1.
- Reset mid-operation: assert `rst_n`=0 during S_MEMWR → `mem_wr` drops to 0 asynchronously and `state`=0 immediately.
